present_dropper: RTL and testbench

PRESENT_DROPPER -- requirements
Module: present_dropper

---
 rtl/present_dropper.sv | 223 ++++++++++++++++++++++
 tb/tb_present_dropper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/present_dropper.sv
`default_nettype none
// ============================================================================
// Module   : present_dropper
// Purpose  : Game object that periodically spawns a falling "present" at a
//            random X position. The present falls once per video frame,
//            optionally rests on the floor for a while, and can be collected
//            by the player at any point during its fall or rest.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1       system clock
//   reset          in   1       asynchronous active-high reset
//   enable         in   1       game running
//   startOfFrame   in   1       one-cycle pulse once per video frame
//   playerHit      in   1       present/player collision (level)
//   randX          in   X_BITS  value from the random location generator
//   randRise       out  1       rise trigger to the random location generator
//   topLeftX       out  X_BITS  present X
//   topLeftY       out  Y_BITS  present Y
//   presentVisible out  1       present drawn
//   collectedPulse out  1       one-cycle pulse on collection
// ----------------------------------------------------------------------------
// Configuration
//   PRESENT_LAND_HOLD_EN  defined  : a landed present stays visible on the
//                                    floor for LAND_FRAMES frames.
//                         undefined: a present that reaches the floor
//                                    disappears on the following cycle.
// ============================================================================
module present_dropper #(
  parameter int X_BITS         = 11,
  parameter int Y_BITS         = 11,
  parameter int MIN_X          = 0,
  parameter int MAX_X          = 607,
  parameter int SPAWN_Y        = 0,
  parameter int FLOOR_Y        = 440,
  parameter int FALL_STEP      = 2,
  parameter int RESPAWN_FRAMES = 120,
  parameter int LAND_FRAMES    = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              startOfFrame,
  input  logic              playerHit,
  input  logic [X_BITS-1:0] randX,
  output logic              randRise,
  output logic [X_BITS-1:0] topLeftX,
  output logic [Y_BITS-1:0] topLeftY,
  output logic              presentVisible,
  output logic              collectedPulse
);

  // The shared frame counter must hold the larger of the two frame budgets.
  localparam int c_CNT_MAX = (RESPAWN_FRAMES > LAND_FRAMES) ? RESPAWN_FRAMES : LAND_FRAMES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_CAPTURE   = 3'd2,
    S_FALLING   = 3'd3,
`ifdef PRESENT_LAND_HOLD_EN
    S_LANDED    = 3'd4,
`endif
    S_COLLECTED = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_rise;
  logic [X_BITS-1:0]  r_x;
  logic [Y_BITS-1:0]  r_y;
  logic               r_vis;
  logic               r_pulse;

  logic [c_CNT_W-1:0] w_cnt_inc;
  int                 w_rand_i;
  logic [X_BITS-1:0]  w_spawn_x;
  logic [Y_BITS:0]    w_y_sum;
  logic               w_at_floor;
  logic [Y_BITS-1:0]  w_y_next;

  assign w_cnt_inc = r_cnt + 1'b1;

  // Clamp the random X into the legal spawn window. The comparison is done
  // in signed int so a zero MIN_X does not degenerate into a constant test.
  assign w_rand_i = int'(randX);

  always_comb begin
    w_spawn_x = randX;
    if (w_rand_i < MIN_X) begin
      w_spawn_x = X_BITS'(MIN_X);
    end else if (w_rand_i > MAX_X) begin
      w_spawn_x = X_BITS'(MAX_X);
    end
  end

  // One extra bit so a step near the top of the Y range cannot wrap below
  // the floor and keep the present falling forever.
  assign w_y_sum    = {1'b0, r_y} + (Y_BITS + 1)'(FALL_STEP);
  assign w_at_floor = (w_y_sum >= (Y_BITS + 1)'(FLOOR_Y));
  assign w_y_next   = w_at_floor ? Y_BITS'(FLOOR_Y) : w_y_sum[Y_BITS-1:0];

`ifndef PRESENT_LAND_HOLD_EN
  logic w_on_floor;
  assign w_on_floor = (r_y == Y_BITS'(FLOOR_Y));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_x     <= X_BITS'(MIN_X);
      r_y     <= Y_BITS'(SPAWN_Y);
      r_vis   <= 1'b0;
      r_pulse <= 1'b0;
    end else if (!enable) begin
      // Pausing the game abandons any present in flight without a collection.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_vis   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rise  <= 1'b0;
          r_vis   <= 1'b0;
          r_pulse <= 1'b0;
          if (startOfFrame) begin
            if (w_cnt_inc == c_CNT_W'(RESPAWN_FRAMES)) begin
              r_cnt   <= '0;
              r_rise  <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        // randRise is high only while in REQ, and REQ is always followed by
        // CAPTURE, so the generator always sees a fresh rising edge.
        S_REQ: begin
          r_rise  <= 1'b0;
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          r_x     <= w_spawn_x;
          r_y     <= Y_BITS'(SPAWN_Y);
          r_vis   <= 1'b1;
          r_state <= S_FALLING;
        end

        S_FALLING: begin
          if (playerHit) begin
            r_vis   <= 1'b0;
            r_pulse <= 1'b1;
            r_state <= S_COLLECTED;
`ifndef PRESENT_LAND_HOLD_EN
          end else if (w_on_floor) begin
            // The floor position is shown for one cycle, then the present goes.
            r_vis   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
`endif
          end else if (startOfFrame) begin
            r_y <= w_y_next;
`ifdef PRESENT_LAND_HOLD_EN
            if (w_at_floor) begin
              r_cnt   <= '0;
              r_state <= S_LANDED;
            end
`endif
          end
        end

`ifdef PRESENT_LAND_HOLD_EN
        S_LANDED: begin
          if (playerHit) begin
            r_vis   <= 1'b0;
            r_pulse <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_COLLECTED;
          end else if (startOfFrame) begin
            if (w_cnt_inc == c_CNT_W'(LAND_FRAMES)) begin
              r_cnt   <= '0;
              r_vis   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
`endif

        S_COLLECTED: begin
          r_pulse <= 1'b0;
          r_vis   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_rise  <= 1'b0;
          r_vis   <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign randRise       = r_rise;
  assign topLeftX       = r_x;
  assign topLeftY       = r_y;
  assign presentVisible = r_vis;
  assign collectedPulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_present_dropper.sv
`default_nettype none
// ============================================================================
// Module   : tb_present_dropper
// Purpose  : Self-checking bench for present_dropper. Expected spawn X values
//            are queued when randX is driven and popped when the present
//            appears; all other expectations come from a small local model.
//            Expectations for the floor behaviour follow PRESENT_LAND_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_present_dropper;

  localparam int TB_X_BITS = 11;
  localparam int TB_Y_BITS = 11;
  localparam int TB_MIN_X  = 20;
  localparam int TB_MAX_X  = 607;
  localparam int TB_FLOOR  = 440;
  localparam int TB_STEP   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 startOfFrame;
  logic                 playerHit;
  logic [TB_X_BITS-1:0] randX;
  logic                 randRise;
  logic [TB_X_BITS-1:0] topLeftX;
  logic [TB_Y_BITS-1:0] topLeftY;
  logic                 presentVisible;
  logic                 collectedPulse;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_x_q[$];

  present_dropper #(
    .MIN_X(TB_MIN_X)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .startOfFrame  (startOfFrame),
    .playerHit     (playerHit),
    .randX         (randX),
    .randRise      (randRise),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .presentVisible(presentVisible),
    .collectedPulse(collectedPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int clamp_x(input int rx);
    if (rx < TB_MIN_X) return TB_MIN_X;
    if (rx > TB_MAX_X) return TB_MAX_X;
    return rx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},     int'(topLeftX), TB_MIN_X);
    check({tag, "_y"},     int'(topLeftY), 0);
    check({tag, "_vis"},   int'(presentVisible), 0);
    check({tag, "_rise"},  int'(randRise), 0);
    check({tag, "_pulse"}, int'(collectedPulse), 0);
  endtask

  // Run frames from IDLE until the request fires, then follow the spawn.
  task automatic spawn(input int rx);
    int  frames;
    bit  rose;
    frames = 0;
    rose   = 1'b0;
    randX  = TB_X_BITS'(rx);
    exp_x_q.push_back(clamp_x(rx));
    while (frames < 200 && !rose) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      frames++;
      if (randRise) rose = 1'b1;
      else repeat (3) tick();
    end
    check("spawn_frames", frames, 120);
    check("rise_no_pulse", int'(collectedPulse), 0);
    check("rise_hidden", int'(presentVisible), 0);
    tick();
    check("rise_single", int'(randRise), 0);
    check("capture_hidden", int'(presentVisible), 0);
    check("capture_no_pulse", int'(collectedPulse), 0);
    tick();
    check("spawn_visible", int'(presentVisible), 1);
    check("spawn_no_pulse", int'(collectedPulse), 0);
    check("sb_pending", exp_x_q.size(), 1);
    if (exp_x_q.size() > 0) check("spawn_x", int'(topLeftX), exp_x_q.pop_front());
    check("spawn_y", int'(topLeftY), 0);
  endtask

  // Fall from the spawn height until Y equals target; returns right after
  // the frame pulse that produced it.
  task automatic fall_to(input int target);
    int frames;
    int exp_y;
    bit done;
    frames = 0;
    exp_y  = 0;
    done   = 1'b0;
    while (frames < 300 && !done) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      frames++;
      exp_y = (exp_y + TB_STEP > TB_FLOOR) ? TB_FLOOR : exp_y + TB_STEP;
      if (int'(topLeftY) == target) done = 1'b1;
      else repeat (3) tick();
    end
    check("fall_frames", frames, target / TB_STEP);
    check("fall_y", int'(topLeftY), exp_y);
    check("fall_visible", int'(presentVisible), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    startOfFrame = 1'b0;
    playerHit    = 1'b0;
    randX        = '0;
    repeat (3) tick();
    check_reset_values("reset");
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    // First spawn, fall to the floor and leave.
    spawn(300);
    fall_to(TB_FLOOR);
`ifdef PRESENT_LAND_HOLD_EN
    tick();
    check("landed_visible", int'(presentVisible), 1);
    check("landed_y", int'(topLeftY), TB_FLOOR);
    repeat (2) tick();
    repeat (59) frame();
    check("landed_hold_visible", int'(presentVisible), 1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("land_timeout_hidden", int'(presentVisible), 0);
    check("land_timeout_no_pulse", int'(collectedPulse), 0);
`else
    tick();
    check("floor_hidden", int'(presentVisible), 0);
    check("floor_no_pulse", int'(collectedPulse), 0);
`endif

    // Upper clamp, then a hit on the very frame that would reach the floor.
    spawn(650);
    fall_to(TB_FLOOR - TB_STEP);
    repeat (3) tick();
    playerHit    = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("hit_floor_pulse", int'(collectedPulse), 1);
    check("hit_floor_hidden", int'(presentVisible), 0);
    check("hit_floor_y_held", int'(topLeftY), TB_FLOOR - TB_STEP);
    tick();
    check("hit_floor_pulse_end", int'(collectedPulse), 0);
    check("hit_floor_no_land", int'(presentVisible), 0);

    // Hit held through IDLE/REQ/CAPTURE is ignored until the fall starts.
    spawn(5);
    tick();
    check("hit_held_pulse", int'(collectedPulse), 1);
    playerHit = 1'b0;
    tick();
    check("hit_held_pulse_end", int'(collectedPulse), 0);

    // Asynchronous reset mid-fall.
    spawn(1000);
    fall_to(100);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    tick();
    reset = 1'b0;
    spawn(300);

    // Dropping enable at the floor, together with a hit, gives no collection.
    fall_to(TB_FLOOR);
    tick();
    enable    = 1'b0;
    playerHit = 1'b1;
    tick();
    check("disable_hidden", int'(presentVisible), 0);
    check("disable_no_pulse", int'(collectedPulse), 0);
    check("disable_no_rise", int'(randRise), 0);
    playerHit = 1'b0;
    repeat (10) frame();
    check("disable_still_hidden", int'(presentVisible), 0);
    enable = 1'b1;
    spawn(123);

    check("sb_empty", exp_x_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
